// File: rtl/line_drawer_pkg.sv
// line_drawer_pkg
//   Shared display constants and line-drawer state encoding.
//   DEF_HOR_ACTIVE_PIXELS / DEF_VER_ACTIVE_PIXELS : default visible area
//   DEF_X_WIDTH / DEF_Y_WIDTH                     : coordinate widths derived from it
//   ld_state_t                                    : IDLE=0, SETUP=1, DRAW=2
package line_drawer_pkg;

  localparam int DEF_HOR_ACTIVE_PIXELS = 640;
  localparam int DEF_VER_ACTIVE_PIXELS = 480;
  localparam int DEF_X_WIDTH = $clog2(DEF_HOR_ACTIVE_PIXELS);
  localparam int DEF_Y_WIDTH = $clog2(DEF_VER_ACTIVE_PIXELS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } ld_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/line_drawer_step.sv
// line_drawer_step
//   Combinational single Bresenham step.
//   cur_x, cur_y        : current pixel position
//   err, dx, dy         : error term and deltas (dx >= 0, dy <= 0), signed
//   sx, sy              : step directions, +1 or -1 (2-bit signed)
//   next_x, next_y      : position after the step
//   next_err            : error term after the step
module line_drawer_step #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 9,
  parameter int CW      = 12
) (
  input  logic        [X_WIDTH-1:0] cur_x,
  input  logic        [Y_WIDTH-1:0] cur_y,
  input  logic signed [CW-1:0]      err,
  input  logic signed [CW-1:0]      dx,
  input  logic signed [CW-1:0]      dy,
  input  logic signed [1:0]         sx,
  input  logic signed [1:0]         sy,
  output logic        [X_WIDTH-1:0] next_x,
  output logic        [Y_WIDTH-1:0] next_y,
  output logic signed [CW-1:0]      next_err
);

  logic signed [CW-1:0] e2;

  always_comb begin
    e2       = err <<< 1;
    next_x   = cur_x;
    next_y   = cur_y;
    next_err = err;
    // Both tests use the pre-step e2, so a diagonal step accumulates dy+dx.
    if (e2 >= dy) begin
      next_err = next_err + dy;
      // Sign-extended direction added modulo 2^X_WIDTH gives cur_x +/- 1.
      next_x   = cur_x + X_WIDTH'(sx);
    end
    if (e2 <= dx) begin
      next_err = next_err + dx;
      next_y   = cur_y + Y_WIDTH'(sy);
    end
  end

endmodule

// File: rtl/line_drawer.sv
// line_drawer
//   Accepts a segment on a start pulse, rasterises it with Bresenham and
//   streams pixel coordinates over valid/ready.
//   clk, rst            : clock, synchronous active-high reset
//   start, ready        : request pulse / idle indication
//   x1, y1, x2, y2      : segment endpoints, latched on accepted start
//   pixel_x, pixel_y    : current pixel
//   pixel_valid         : pixel present (low for off-screen positions)
//   pixel_ready         : downstream accepts on valid && ready
//
// state | meaning
// IDLE  | waiting for start, ready=1
// SETUP | one cycle computing dx, dy, sx, sy, err
// DRAW  | walking the segment, one position per step
module line_drawer
  import line_drawer_pkg::*;
#(
  parameter  int HOR_ACTIVE_PIXELS = DEF_HOR_ACTIVE_PIXELS,
  parameter  int VER_ACTIVE_PIXELS = DEF_VER_ACTIVE_PIXELS,
  localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ready,
  input  logic [X_WIDTH-1:0] x1,
  input  logic [Y_WIDTH-1:0] y1,
  input  logic [X_WIDTH-1:0] x2,
  input  logic [Y_WIDTH-1:0] y2,
  output logic [X_WIDTH-1:0] pixel_x,
  output logic [Y_WIDTH-1:0] pixel_y,
  output logic               pixel_valid,
  input  logic               pixel_ready
);

  localparam int CW = max_int(X_WIDTH, Y_WIDTH) + 2;

  ld_state_t            state;
  logic [X_WIDTH-1:0]   cur_x, end_x;
  logic [Y_WIDTH-1:0]   cur_y, end_y;
  logic signed [CW-1:0] err, dx, dy;
  logic signed [1:0]    sx, sy;

  logic signed [CW-1:0] x_diff, y_diff, abs_x, abs_y;
  logic [X_WIDTH-1:0]   nxt_x;
  logic [Y_WIDTH-1:0]   nxt_y;
  logic signed [CW-1:0] nxt_err;
  logic                 at_end, advance;

  function automatic logic clipped(input logic [X_WIDTH-1:0] x, input logic [Y_WIDTH-1:0] y);
    return (int'(x) >= HOR_ACTIVE_PIXELS) || (int'(y) >= VER_ACTIVE_PIXELS);
  endfunction

  assign ready   = (state == IDLE);
  assign pixel_x = cur_x;
  assign pixel_y = cur_y;

  // SETUP works from the latched cur/end registers, not the live inputs.
  assign x_diff = $signed(CW'(end_x)) - $signed(CW'(cur_x));
  assign y_diff = $signed(CW'(end_y)) - $signed(CW'(cur_y));
  assign abs_x  = x_diff[CW-1] ? -x_diff : x_diff;
  assign abs_y  = y_diff[CW-1] ? -y_diff : y_diff;

  assign at_end = (cur_x == end_x) && (cur_y == end_y);
  // In DRAW, valid=0 means the position is clipped and steps unconditionally.
  assign advance = !pixel_valid || pixel_ready;

  line_drawer_step #(
    .X_WIDTH(X_WIDTH),
    .Y_WIDTH(Y_WIDTH),
    .CW     (CW)
  ) u_step (
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .err     (err),
    .dx      (dx),
    .dy      (dy),
    .sx      (sx),
    .sy      (sy),
    .next_x  (nxt_x),
    .next_y  (nxt_y),
    .next_err(nxt_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pixel_valid <= 1'b0;
      cur_x       <= '0;
      cur_y       <= '0;
      end_x       <= '0;
      end_y       <= '0;
      err         <= '0;
      dx          <= '0;
      dy          <= '0;
      sx          <= '0;
      sy          <= '0;
    end else begin
      case (state)
        IDLE: begin
          pixel_valid <= 1'b0;
          if (start) begin
            cur_x <= x1;
            cur_y <= y1;
            end_x <= x2;
            end_y <= y2;
            state <= SETUP;
          end
        end
        SETUP: begin
          dx          <= abs_x;
          dy          <= -abs_y;
          sx          <= (cur_x < end_x) ? 2'sb01 : 2'sb11;
          sy          <= (cur_y < end_y) ? 2'sb01 : 2'sb11;
          err         <= abs_x - abs_y;
          pixel_valid <= !clipped(cur_x, cur_y);
          state       <= DRAW;
        end
        DRAW: begin
          if (advance) begin
            if (at_end) begin
              pixel_valid <= 1'b0;
              state       <= IDLE;
            end else begin
              cur_x       <= nxt_x;
              cur_y       <= nxt_y;
              err         <= nxt_err;
              pixel_valid <= !clipped(nxt_x, nxt_y);
            end
          end
        end
        default: begin
          pixel_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_drawer.sv
// tb_line_drawer
//   Table-driven check of line_drawer: each record holds a segment, its
//   position count, an optional stall length on the 2nd pixel and the
//   expected emitted pixels. Reset-mid-line is a hand-written sequence.
module tb_line_drawer;
  import line_drawer_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst, start, pixel_ready;
  logic                   ready, pixel_valid;
  logic [DEF_X_WIDTH-1:0] x1, x2, pixel_x;
  logic [DEF_Y_WIDTH-1:0] y1, y2, pixel_y;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int x1; int y1; int x2; int y2;
    int npos;   // positions walked, clipped included
    int stall;  // cycles pixel_ready held low on the 2nd pixel
    int first;  // index into exp_x/exp_y
    int count;  // pixels actually emitted
  } vec_t;

  vec_t vecs[$];
  int   exp_x[$];
  int   exp_y[$];

  always #5 clk = ~clk;

  line_drawer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ready      (ready),
    .x1         (x1),
    .y1         (y1),
    .x2         (x2),
    .y2         (y2),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int ax1, input int ay1, input int ax2, input int ay2,
                         input int npos, input int stall, input int count);
    vec_t v;
    v.x1 = ax1; v.y1 = ay1; v.x2 = ax2; v.y2 = ay2;
    v.npos = npos; v.stall = stall; v.count = count;
    v.first = exp_x.size();
    vecs.push_back(v);
  endtask

  task automatic add_pix(input int px, input int py);
    exp_x.push_back(px);
    exp_y.push_back(py);
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int got, first_cyc, ready_cyc, stalled;
    v = vecs[k];
    got = 0; first_cyc = -1; ready_cyc = -1; stalled = 0;
    @(negedge clk);
    start = 1'b1;
    x1 = DEF_X_WIDTH'(v.x1); y1 = DEF_Y_WIDTH'(v.y1);
    x2 = DEF_X_WIDTH'(v.x2); y2 = DEF_Y_WIDTH'(v.y2);
    pixel_ready = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 1) begin
        check($sformatf("v%0d_ready_drop", k), int'(ready), 0);
        // Inputs change after acceptance; the latched segment must win.
        x1 = '0; y1 = '0; x2 = '1; y2 = '1;
      end
      if (ready) begin
        ready_cyc = cyc;
        break;
      end
      pixel_ready = 1'b1;
      if (pixel_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (got == 1 && stalled < v.stall) begin
          pixel_ready = 1'b0;
          stalled++;
          check($sformatf("v%0d_stall%0d_x", k, stalled), int'(pixel_x), exp_x[v.first+1]);
          check($sformatf("v%0d_stall%0d_y", k, stalled), int'(pixel_y), exp_y[v.first+1]);
          start = 1'b1;
          x1 = 10'd7; y1 = 9'd7; x2 = 10'd20; y2 = 9'd3;
        end else begin
          if (got < v.count) begin
            check($sformatf("v%0d_pix%0d_x", k, got), int'(pixel_x), exp_x[v.first+got]);
            check($sformatf("v%0d_pix%0d_y", k, got), int'(pixel_y), exp_y[v.first+got]);
          end
          got++;
        end
      end
    end
    check($sformatf("v%0d_pix_count", k), got, v.count);
    check($sformatf("v%0d_first_valid_cyc", k), first_cyc, 2);
    check($sformatf("v%0d_ready_return_cyc", k), ready_cyc, 2 + v.npos + v.stall);
    check($sformatf("v%0d_valid_after_end", k), int'(pixel_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;

    add_vec(0, 240, 3, 240, 4, 0, 4);
    add_pix(0, 240); add_pix(1, 240); add_pix(2, 240); add_pix(3, 240);
    add_vec(5, 5, 6, 9, 5, 0, 5);
    add_pix(5, 5); add_pix(5, 6); add_pix(6, 7); add_pix(6, 8); add_pix(6, 9);
    add_vec(3, 0, 0, 0, 4, 0, 4);
    add_pix(3, 0); add_pix(2, 0); add_pix(1, 0); add_pix(0, 0);
    add_vec(10, 10, 10, 10, 1, 0, 1);
    add_pix(10, 10);
    add_vec(0, 0, 4, 4, 5, 3, 5);
    add_pix(0, 0); add_pix(1, 1); add_pix(2, 2); add_pix(3, 3); add_pix(4, 4);
    add_vec(638, 0, 641, 0, 4, 0, 2);
    add_pix(638, 0); add_pix(639, 0);
    add_vec(1, 2, 3, 3, 3, 0, 3);
    add_pix(1, 2); add_pix(2, 3); add_pix(3, 3);

    rst = 1'b1; start = 1'b0; pixel_ready = 1'b0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", int'(ready), 1);
    check("rst_valid", int'(pixel_valid), 0);
    check("rst_pixel_x", int'(pixel_x), 0);
    check("rst_pixel_y", int'(pixel_y), 0);

    for (int k = 0; k < 6; k++) run_vec(k);

    // Reset while the 3rd pixel of (0,0)->(9,0) is presented.
    @(negedge clk);
    start = 1'b1; pixel_ready = 1'b1;
    x1 = 10'd0; y1 = 9'd0; x2 = 10'd9; y2 = 9'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_pix2_valid", int'(pixel_valid), 1);
    check("mid_rst_pix2_x", int'(pixel_x), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", int'(pixel_valid), 0);
    check("mid_rst_ready", int'(ready), 1);
    nv = 0;
    repeat (12) begin
      @(negedge clk);
      if (pixel_valid) nv++;
    end
    check("mid_rst_no_more_pixels", nv, 0);

    run_vec(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/line_drawer.md
Name: line_drawer

Overview:
Responder end of the line-drawer handshake used by plot/logic controllers. It accepts a segment (x1,y1)-(x2,y2) on a one-cycle start pulse, rasterises it with integer Bresenham, and streams pixel coordinates to the framebuffer writer over a valid/ready interface. It sits between the function-plotting controller and the framebuffer write port.

Parameters:
HOR_ACTIVE_PIXELS, 640, visible width; X_WIDTH = $clog2(HOR_ACTIVE_PIXELS)
VER_ACTIVE_PIXELS, 480, visible height; Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request pulse; sampled only when ready=1
ready  out  1  high iff state==IDLE (decoded from registered state)
x1  in  X_WIDTH  start x, latched on accepted start
y1  in  Y_WIDTH  start y, latched on accepted start
x2  in  X_WIDTH  end x, latched on accepted start
y2  in  Y_WIDTH  end y, latched on accepted start
pixel_x  out  X_WIDTH  current pixel x
pixel_y  out  Y_WIDTH  current pixel y
pixel_valid  out  1  pixel_x/pixel_y hold a pixel to write
pixel_ready  in  1  downstream accepts pixel when valid&&ready

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, ready=1, pixel_valid=0, pixel_x=0, pixel_y=0, internal err/step registers 0. rst mid-line aborts immediately; the pending pixel is dropped and no further pixels are emitted.
- States: IDLE, SETUP, DRAW.
- IDLE: on edge with start=1 -> latch x1,y1,x2,y2 into cur_x,cur_y,end_x,end_y; go SETUP. ready drops after that same edge, so an initiator that checks ready two edges after raising start sees 0.
- SETUP (1 cycle): dx=|x2-x1|, dy=-|y2-y1|, sx=(x1<x2)?+1:-1, sy=(y1<y2)?+1:-1, err=dx+dy. Signed math, width max(X_WIDTH,Y_WIDTH)+2. -> DRAW.
- DRAW: pixel_x/pixel_y = cur_x/cur_y; pixel_valid=1 unless clipped. A step happens on an edge where (pixel_valid&&pixel_ready), or where the pixel is clipped (pixel_valid=0, unconditional advance).
- Step: if cur==end -> IDLE (ready=1 next cycle). Otherwise e2=2*err; if e2>=dy {err+=dy; cur_x+=sx}; if e2<=dx {err+=dx; cur_y+=sy}; both updates use pre-step err (a diagonal step adds dy+dx).
- Latency: start edge E -> first pixel valid after E+2. Throughput 1 pixel/cycle while pixel_ready=1. After the final accept, ready=1 on the next cycle.
- Backpressure: while pixel_valid=1 and pixel_ready=0, pixel_x, pixel_y, pixel_valid and all internal state hold stable.
- Clipping: a pixel with cur_x>=HOR_ACTIVE_PIXELS or cur_y>=VER_ACTIVE_PIXELS is not emitted (pixel_valid=0). Stepping continues at 1 pixel/cycle.
- Degenerate segment (x1==x2, y1==y2): exactly one pixel is emitted.
- start while not IDLE is ignored. Input coordinate changes after acceptance have no effect.
- Endpoints are inclusive. Every segment emits max(|dx|,|dy|)+1 pixel positions, clipped ones included.

Decomposition:
- Shared display header/package: HOR_ACTIVE_PIXELS/VER_ACTIVE_PIXELS defaults, X_WIDTH/Y_WIDTH derivation, line-drawer state encodings (IDLE=0, SETUP=1, DRAW=2).
- One sub-module, line_drawer_step: combinational Bresenham step taking cur_x, cur_y, err, dx, dy, sx, sy and producing next cur_x, cur_y, err. The top module owns the FSM, handshake and clipping.

Test Plan:
- (0,240)->(3,240), pixel_ready=1 -> pixels (0,240),(1,240),(2,240),(3,240) on consecutive cycles, first valid 2 cycles after start; ready=1 cycle after the last accept.
- (5,5)->(6,9) -> exactly (5,5),(5,6),(6,7),(6,8),(6,9).
- (3,0)->(0,0), negative direction -> (3,0),(2,0),(1,0),(0,0). Also (10,10)->(10,10) -> single pixel (10,10).
- (0,0)->(4,4) with pixel_ready low 3 cycles on the 2nd pixel -> (1,1) held stable with valid=1 throughout; output sequence unchanged; extra start pulses during the line ignored.
- HOR=640, (638,0)->(641,0) -> only (638,0),(639,0) emitted; ready returns 4 cycles after the first pixel position.
- rst asserted during the 3rd pixel of (0,0)->(9,0) -> next cycle pixel_valid=0, ready=1, no further pixels; a new start then draws correctly.
